conbus_qarb: RTL and testbench
==============================

Name: conbus_qarb

Overview:
- Eight-master round-robin arbiter for the shared Wishbone interconnect, with a per-grant transfer quota.
- A master that keeps its cycle asserted is forced to hand over the bus after QUOTA completed transfers. Handover happens only at a transfer boundary, and only if another master is waiting and the holder has not locked the bus.
- Sits between the masters' CYC lines and the conbus mux select. Drop-in replacement for the plain round-robin arbiter where one master (e.g. a DMA) can starve the CPU.

Parameters:
- QUOTA, 16, completed transfers allowed per grant tenure before forced handover; 0 disables forced handover.
- CNT_W, 5, transfer counter width; QUOTA must be at most 2^CNT_W - 1.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- req  in  8  per-master bus request (master CYC).
- lock  in  8  per-master no-preempt request; meaningful only for the granted master.
- ack  in  1  transfer termination (slave ACK or ERR) of the granted master's current transfer.
- gnt  out  8  one-hot grant, registered.
- gnt_id  out  3  binary index of gnt, registered.
- preempt  out  1  one-cycle pulse, registered; high in the first cycle of a grant produced by forced handover.

Behaviour:
- Reset (async assert, sync release behaviour irrelevant): gnt=8'h01, gnt_id=0, cnt=0, preempt=0.
- cur = gnt_id. Round-robin search order is cur+1, cur+2 … cur+7, indices modulo 8. "next" is the first index in that order with req set. "other" means any req bit other than cur is set.
- The grant state updates every rising edge. gnt and gnt_id always change together and stay consistent: gnt == 1<<gnt_id.
- Voluntary handover: if req[cur]=0 and other, then next cycle gnt=next, cnt=0, preempt=0.
- Park: if req[cur]=0 and no other request, gnt is held (bus parked on last owner), cnt=0.
- Counting: while req[cur]=1, each cycle with ack=1 does cnt <= min(cnt+1, QUOTA); counting saturates.
- Forced handover: fires when all of the following hold:
  - QUOTA != 0, req[cur]=1, ack=1
  - cnt >= QUOTA-1 (this ack completes the QUOTA-th transfer)
  - lock[cur]=0
  - other is true
  Then next cycle gnt=next, cnt=0, preempt=1 for exactly that one cycle.
- Handover never happens on a cycle with req[cur]=1 and ack=0, so an in-flight transfer is never cut.
- Quota reached with no other requester: grant kept, cnt held at QUOTA. The first later ack with other true triggers forced handover, subject to lock.
- Locked holder: cnt still counts and saturates, but no forced handover. After lock drops, the next ack with other true hands over.
- Simultaneous req[cur] falling and ack: the voluntary rule applies, preempt=0.
- The newly granted master's first ack can arrive no earlier than the cycle after the grant change. Any ack in the grant-change cycle is attributed to the old owner and discarded.
- Reset asserted mid-tenure: immediate return to reset values regardless of req/lock/ack.
- lock bits of non-granted masters are ignored.
- Combinational path req/lock/ack -> next grant only; all outputs come straight from flops.

Test Plan:
- Reset, req=0 -> gnt=8'h01, gnt_id=0, preempt=0; stays parked for 20 cycles.
- Voluntary rotation:
  - Setup: req=8'h01 then req=8'h0A with master 0 releasing.
  - Expect: gnt 01 -> 02 one cycle later.
  - Then drop req[1] -> gnt=08, preempt never high.
- Quota preemption, QUOTA=4:
  - Stimulus: req=8'h11, master 0 holds CYC, ack pulses every 2 cycles.
  - Expect: gnt=10 in the cycle after the 4th ack, preempt=1 for one cycle.
  - Master 4 then gets 4 transfers and gnt returns to 01.
- Lock: same as the quota case with lock[0]=1.
  - Expect: gnt stays 01 after 10 acks.
  - Deassert lock[0]; the next ack moves gnt to 10 with preempt=1.
- Wrap and no-competitor:
  - Wrap: gnt=80, req=8'h81, req[7] drops -> gnt=01.
  - No competitor, QUOTA=4: req=8'h01, 6 acks, gnt stays 01.
  - Then raise req[2]; the next ack gives gnt=04, preempt=1.
- Mid-transfer and async reset:
  - Quota reached with ack=0 -> no handover until ack.
  - sys_rst pulse between clock edges while gnt=20 -> gnt=01 immediately, cnt=0.

Source files
------------

// File: rtl/conbus_qarb.sv
// Eight-master round-robin bus arbiter with a per-grant transfer quota.
// A holder that keeps its request up past QUOTA transfers is forced off the bus.
module conbus_qarb #(
   parameter int QUOTA = 16,
   parameter int CNT_W = 5
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] req,
   input  logic [7:0] lock,
   input  logic       ack,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       preempt
);

   localparam logic [CNT_W-1:0] QuotaC   = CNT_W'(QUOTA);
   localparam logic [CNT_W-1:0] QuotaM1C = (QUOTA == 0) ? '0 : CNT_W'(QUOTA - 1);

   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       gntId_q, gntId_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             preempt_q, preempt_d;
   logic             fresh_q, fresh_d;

   logic [2:0] cur;
   logic [2:0] idx;
   logic [2:0] nextId;
   logic       found;
   logic       other;
   logic       ackEff;
   logic       quotaHit;

   // Next-owner search, quota counting and handover decision for the coming edge.
   always_comb begin
      cur       = gntId_q;
      other     = |(req & ~(8'b1 << cur));
      nextId    = cur;
      found     = 1'b0;
      idx       = cur;
      for (int i = 1; i < 8; i++) begin
         idx = cur + 3'(i);
         if (!found && req[idx]) begin
            nextId = idx;
            found  = 1'b1;
         end
      end
      // An ack in the first cycle of a new grant belongs to the previous owner.
      ackEff    = ack & ~fresh_q;
      quotaHit  = (QUOTA != 0) && (cnt_q >= QuotaM1C);

      gntId_d   = gntId_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      fresh_d   = 1'b0;

      if (!req[cur]) begin
         cnt_d = '0;
         if (other) begin
            gntId_d = nextId;
            fresh_d = 1'b1;
         end
      end else if (ackEff) begin
         if (quotaHit && !lock[cur] && other) begin
            gntId_d   = nextId;
            cnt_d     = '0;
            preempt_d = 1'b1;
            fresh_d   = 1'b1;
         end else if (cnt_q >= QuotaC) begin
            cnt_d = QuotaC;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      gnt_d = 8'b1 << gntId_d;
   end

   // Grant state registers; reset parks the bus on master 0.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gnt_q     <= 8'h01;
         gntId_q   <= 3'd0;
         cnt_q     <= '0;
         preempt_q <= 1'b0;
         fresh_q   <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         gntId_q   <= gntId_d;
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
         fresh_q   <= fresh_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gntId_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_conbus_qarb.sv
// Directed and randomized bench for conbus_qarb (QUOTA=4) against a
// transaction-level model of owner, completed-transfer count and handover.
module tb_conbus_qarb;

   localparam int Q = 4;

   logic       sysClk = 1'b0;
   logic       sysRst = 1'b1;
   logic [7:0] rq     = 8'h00;
   logic [7:0] lk     = 8'h00;
   logic       ak     = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gntId;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   int mOwner = 0;
   int mDone  = 0;
   bit mFresh = 0;
   bit mPre   = 0;

   conbus_qarb #(.QUOTA(Q), .CNT_W(5)) dut (
      .sys_clk (sysClk),
      .sys_rst (sysRst),
      .req     (rq),
      .lock    (lk),
      .ack     (ak),
      .gnt     (gnt),
      .gnt_id  (gntId),
      .preempt (preempt)
   );

   always #5 sysClk = ~sysClk;

   // Model: owner index, transfers completed this tenure, first-cycle flag.
   task automatic modelReset();
      mOwner = 0;
      mDone  = 0;
      mFresh = 0;
      mPre   = 0;
   endtask

   task automatic modelStep(input logic [7:0] r, input logic [7:0] l, input logic a);
      int  nxt;
      bit  oth;
      bit  counted;
      nxt = mOwner;
      oth = 0;
      for (int k = 7; k >= 1; k--) begin
         if (r[(mOwner + k) % 8]) begin
            nxt = (mOwner + k) % 8;
            oth = 1;
         end
      end
      counted = a && !mFresh;
      mPre    = 0;
      if (!r[mOwner]) begin
         mDone  = 0;
         mFresh = oth;
         if (oth) mOwner = nxt;
      end else if (counted) begin
         if (Q != 0 && mDone + 1 >= Q && !l[mOwner] && oth) begin
            mOwner = nxt;
            mDone  = 0;
            mPre   = 1;
            mFresh = 1;
         end else begin
            mDone  = (mDone + 1 > Q) ? Q : mDone + 1;
            mFresh = 0;
         end
      end else begin
         mFresh = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] expG;
      expG = 8'h01 << mOwner;
      checks++;
      assert (gnt === expG) else begin
         errors++;
         $error("[TB] FAIL %s gnt observed %h expected %h", tag, gnt, expG);
      end
      checks++;
      assert (gntId === 3'(mOwner)) else begin
         errors++;
         $error("[TB] FAIL %s gnt_id observed %0d expected %0d", tag, gntId, mOwner);
      end
      checks++;
      assert (preempt === mPre) else begin
         errors++;
         $error("[TB] FAIL %s preempt observed %b expected %b", tag, preempt, mPre);
      end
   endtask

   task automatic expectFixed(input string tag, input logic [7:0] g, input logic p);
      checks++;
      assert (gnt === g && preempt === p) else begin
         errors++;
         $error("[TB] FAIL %s gnt/preempt observed %h/%b expected %h/%b", tag, gnt, preempt, g, p);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] l, input logic a, input string tag);
      rq = r;
      lk = l;
      ak = a;
      modelStep(r, l, a);
      @(posedge sysClk);
      #1;
      checkOutput(tag);
   endtask

   task automatic ackPairs(input logic [7:0] r, input logic [7:0] l, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus(r, l, 1'b0, tag);
         applyStimulus(r, l, 1'b1, tag);
      end
   endtask

   // Linear directed sequence followed by a randomized soak.
   initial begin
      modelReset();
      repeat (2) @(posedge sysClk);
      #1;
      checkOutput("reset");
      sysRst = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus(8'h00, 8'h00, 1'b0, "park");
      expectFixed("park_end", 8'h01, 1'b0);

      applyStimulus(8'h01, 8'h00, 1'b0, "vol_hold");
      applyStimulus(8'h0A, 8'h00, 1'b0, "vol_rot");
      expectFixed("vol_01_02", 8'h02, 1'b0);
      applyStimulus(8'h08, 8'h00, 1'b0, "vol_drop1");
      expectFixed("vol_02_08", 8'h08, 1'b0);
      applyStimulus(8'h01, 8'h00, 1'b0, "back_to_0");

      ackPairs(8'h11, 8'h00, 4, "quota0");
      expectFixed("quota_0_to_4", 8'h10, 1'b1);
      ackPairs(8'h11, 8'h00, 4, "quota4");
      expectFixed("quota_4_to_0", 8'h01, 1'b1);

      ackPairs(8'h11, 8'h01, 10, "lock");
      expectFixed("lock_holds", 8'h01, 1'b0);
      applyStimulus(8'h11, 8'h00, 1'b0, "unlock");
      applyStimulus(8'h11, 8'h00, 1'b1, "unlock_ack");
      expectFixed("unlock_handover", 8'h10, 1'b1);
      applyStimulus(8'h01, 8'h00, 1'b0, "back_to_0b");

      applyStimulus(8'h80, 8'h00, 1'b0, "to7");
      applyStimulus(8'h81, 8'h00, 1'b0, "hold7");
      applyStimulus(8'h81, 8'h00, 1'b0, "hold7");
      expectFixed("hold7", 8'h80, 1'b0);
      applyStimulus(8'h01, 8'h00, 1'b0, "wrap");
      expectFixed("wrap_80_01", 8'h01, 1'b0);

      ackPairs(8'h01, 8'h00, 6, "nocomp");
      expectFixed("nocomp_hold", 8'h01, 1'b0);
      applyStimulus(8'h05, 8'h00, 1'b0, "comp_arrive");
      applyStimulus(8'h05, 8'h00, 1'b1, "comp_ack");
      expectFixed("nocomp_preempt", 8'h04, 1'b1);

      ackPairs(8'h04, 8'h00, 4, "sat2");
      for (int i = 0; i < 5; i++) applyStimulus(8'h05, 8'h00, 1'b0, "inflight");
      expectFixed("inflight_hold", 8'h04, 1'b0);
      applyStimulus(8'h05, 8'h00, 1'b1, "inflight_ack");
      expectFixed("inflight_ack", 8'h01, 1'b1);

      applyStimulus(8'h20, 8'h00, 1'b0, "to5");
      ackPairs(8'h21, 8'h00, 2, "tenure5");
      expectFixed("tenure5", 8'h20, 1'b0);
      #3 sysRst = 1'b1;
      #1;
      modelReset();
      checkOutput("async_rst");
      expectFixed("async_rst", 8'h01, 1'b0);
      #2 sysRst = 1'b0;
      ackPairs(8'h03, 8'h00, 3, "post_rst");
      expectFixed("post_rst_cnt0", 8'h01, 1'b0);
      ackPairs(8'h03, 8'h00, 1, "post_rst_q");
      expectFixed("post_rst_quota", 8'h02, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         logic [7:0] r;
         logic [7:0] l;
         logic       a;
         r = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 3) != 0) r[mOwner] = 1'b1;
         l = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         a = 1'($urandom);
         applyStimulus(r, l, a, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
